// File: rtl/goertzel_power_detector_if.sv
// Handshake and result bundle between the detector and its Goertzel/receiver neighbours.
// Carries peak_o only when PEAK_TRACK_EN is defined.
interface goertzel_power_detector_if #(
   parameter int DW = 16
);
   logic            enable_i;
   logic [2*DW-1:0] power_i;
   logic            done_i;
   logic [2*DW-1:0] thresh_on_i;
   logic [2*DW-1:0] thresh_off_i;
   logic            start_o;
   logic [2*DW-1:0] avg_o;
   logic            avg_valid_o;
   logic            detect_o;
`ifdef PEAK_TRACK_EN
   logic [2*DW-1:0] peak_o;
`endif

   modport master (
      output enable_i, power_i, done_i, thresh_on_i, thresh_off_i,
      input  start_o, avg_o, avg_valid_o, detect_o
`ifdef PEAK_TRACK_EN
      , input peak_o
`endif
   );

   modport slave (
      input  enable_i, power_i, done_i, thresh_on_i, thresh_off_i,
      output start_o, avg_o, avg_valid_o, detect_o
`ifdef PEAK_TRACK_EN
      , output peak_o
`endif
   );
endinterface

// File: rtl/goertzel_power_detector.sv
// Sequences the Goertzel stage, averages the last 2^AVG_POW2 powers and raises a hysteretic detect flag.
// Optional build macro PEAK_TRACK_EN adds a running peak of the valid averages.
module goertzel_power_detector #(
   parameter int DW         = 16,
   parameter int AVG_POW2   = 2,
   parameter int HOLD_COUNT = 3
) (
   input logic                      clk,
   input logic                      rst,
   goertzel_power_detector_if.slave bus
);
   localparam int PW     = 2 * DW;
   localparam int SW     = PW + AVG_POW2;
   localparam int N      = 1 << AVG_POW2;
   localparam int FILL_W = AVG_POW2 + 1;
   localparam int HOLD_W = $clog2(HOLD_COUNT + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_COUNT);

   typedef enum logic [2:0] {IDLE, START, WAIT, UPDATE, COMPARE} state_t;

   state_t                state;
   logic [PW-1:0]         pwr_p0;
   logic [SW-1:0]         sum_p1;
   logic [PW-1:0]         ring [N];
   logic [AVG_POW2-1:0]   wr_ptr;
   logic [FILL_W-1:0]     fill;
   logic [HOLD_W-1:0]     hold;
   logic [HOLD_W-1:0]     hold_inc;
   logic [PW-1:0]         avg_now;
   logic [PW-1:0]         avg_r;
   logic                  avg_valid_r;
   logic                  detect_r;
`ifdef PEAK_TRACK_EN
   logic [PW-1:0]         peak_r;
`endif

   // The sum holds exactly N values of PW bits, so the shifted result always fits PW bits.
   function automatic logic [PW-1:0] avg_of(input logic [SW-1:0] s);
      return PW'(s >> AVG_POW2);
   endfunction

   assign avg_now  = avg_of(sum_p1);
   assign hold_inc = (hold == HOLD_MAX) ? hold : hold + HOLD_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pwr_p0      <= '0;
         sum_p1      <= '0;
         for (int i = 0; i < N; i++) ring[i] <= '0;
         wr_ptr      <= '0;
         fill        <= '0;
         hold        <= '0;
         avg_r       <= '0;
         avg_valid_r <= 1'b0;
         detect_r    <= 1'b0;
`ifdef PEAK_TRACK_EN
         peak_r      <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.enable_i) begin
                  sum_p1      <= '0;
                  for (int i = 0; i < N; i++) ring[i] <= '0;
                  wr_ptr      <= '0;
                  fill        <= '0;
                  hold        <= '0;
                  avg_valid_r <= 1'b0;
                  detect_r    <= 1'b0;
`ifdef PEAK_TRACK_EN
                  peak_r      <= '0;
`endif
                  state       <= START;
               end
            end
            START: state <= WAIT;
            // capture stage: power latched on done
            WAIT: begin
               if (bus.done_i) begin
                  pwr_p0 <= bus.power_i;
                  state  <= UPDATE;
               end
            end
            // accumulate stage: sum never underflows since it always equals the ring contents
            UPDATE: begin
               sum_p1       <= sum_p1 + SW'(pwr_p0) - SW'(ring[wr_ptr]);
               ring[wr_ptr] <= pwr_p0;
               wr_ptr       <= wr_ptr + AVG_POW2'(1);
               if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
               state        <= COMPARE;
            end
            // decision stage: on-condition is checked first so it wins over release
            COMPARE: begin
               avg_r <= avg_now;
               if (fill == FILL_FULL) begin
                  avg_valid_r <= 1'b1;
                  if (avg_now > bus.thresh_on_i) begin
                     hold <= hold_inc;
                     if (hold_inc == HOLD_MAX) detect_r <= 1'b1;
                  end else begin
                     hold <= '0;
                     if (avg_now < bus.thresh_off_i) detect_r <= 1'b0;
                  end
`ifdef PEAK_TRACK_EN
                  if (avg_now > peak_r) peak_r <= avg_now;
`endif
               end
               state <= bus.enable_i ? START : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.start_o     = (state == START);
   assign bus.avg_o       = avg_r;
   assign bus.avg_valid_o = avg_valid_r;
   assign bus.detect_o    = detect_r;
`ifdef PEAK_TRACK_EN
   assign bus.peak_o      = peak_r;
`endif

endmodule
